// File: rtl/even_odd_pkg.sv
// even_odd_pkg: shared state type and default sizing for the even/odd window checker
package even_odd_pkg;
    typedef enum logic [1:0] {IDLE, COUNT, REPORT} eo_state_t;
    localparam int EO_WIDTH_DEF  = 8;
    localparam int EO_WINDOW_DEF = 16;
endpackage

// File: rtl/even_odd_win_ctr.sv
// even_odd_win_ctr: window FSM, even/odd counters and report registers
// EVEN_ODD_PARITY_EN adds an odd-parity sample counter reported with the window
module even_odd_win_ctr
    import even_odd_pkg::*;
#(
    parameter int WINDOW = EO_WINDOW_DEF,
    parameter int CNT_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             acc,
    input  logic             lsb,
    input  logic             flush,
`ifdef EVEN_ODD_PARITY_EN
    input  logic             par,
    output logic [CNT_W-1:0] win_par_odd,
`endif
    output eo_state_t        state,
    output logic             win_done,
    output logic [CNT_W-1:0] win_even,
    output logic [CNT_W-1:0] win_odd
);
    eo_state_t        state_d;
    logic [CNT_W-1:0] ec_q, oc_q, ec_d, oc_d;
`ifdef EVEN_ODD_PARITY_EN
    logic [CNT_W-1:0] pc_q, pc_d;
`endif
    // flush clears first so a same-cycle accept becomes sample one of the new window
    always_comb begin
        state_d = state;
        ec_d    = ec_q;
        oc_d    = oc_q;
`ifdef EVEN_ODD_PARITY_EN
        pc_d    = pc_q;
`endif
        if (state == REPORT || flush) begin
            state_d = IDLE;
            ec_d    = '0;
            oc_d    = '0;
`ifdef EVEN_ODD_PARITY_EN
            pc_d    = '0;
`endif
        end
        if (state != REPORT && acc) begin
            ec_d    = ec_d + CNT_W'(!lsb);
            oc_d    = oc_d + CNT_W'(lsb);
`ifdef EVEN_ODD_PARITY_EN
            pc_d    = pc_d + CNT_W'(par);
`endif
            state_d = (ec_d + oc_d == CNT_W'(WINDOW)) ? REPORT : COUNT;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ec_q     <= '0;
            oc_q     <= '0;
            win_even <= '0;
            win_odd  <= '0;
`ifdef EVEN_ODD_PARITY_EN
            pc_q        <= '0;
            win_par_odd <= '0;
`endif
        end else begin
            state <= state_d;
            ec_q  <= ec_d;
            oc_q  <= oc_d;
`ifdef EVEN_ODD_PARITY_EN
            pc_q  <= pc_d;
`endif
            if (state_d == REPORT) begin
                win_even <= ec_d;
                win_odd  <= oc_d;
`ifdef EVEN_ODD_PARITY_EN
                win_par_odd <= pc_d;
`endif
            end
        end
    end
    assign win_done = (state == REPORT);
endmodule

// File: rtl/even_odd_window_checker.sv
// even_odd_window_checker: streaming even/odd classifier with windowed counts
// EVEN_ODD_PARITY_EN adds the parity and win_par_odd outputs
module even_odd_window_checker
    import even_odd_pkg::*;
#(
    parameter int WIDTH  = EO_WIDTH_DEF,
    parameter int WINDOW = EO_WINDOW_DEF,
    parameter int CNT_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic             even,
    output logic             odd,
    output logic             out_valid,
`ifdef EVEN_ODD_PARITY_EN
    output logic             parity,
    output logic [CNT_W-1:0] win_par_odd,
`endif
    output logic             win_done,
    output logic [CNT_W-1:0] win_even,
    output logic [CNT_W-1:0] win_odd
);
    if (WIDTH < 1 || WINDOW < 1 || CNT_W < $clog2(WINDOW + 1)) begin : g_bad_params
        $error("even_odd_window_checker: invalid WIDTH/WINDOW/CNT_W");
    end
    eo_state_t state;
    logic      acc;
    assign in_ready = !rst && (state != REPORT);
    assign acc      = in_valid && in_ready;
    always_ff @(posedge clk) begin
        if (rst) begin
            even      <= 1'b0;
            odd       <= 1'b0;
            out_valid <= 1'b0;
`ifdef EVEN_ODD_PARITY_EN
            parity    <= 1'b0;
`endif
        end else begin
            out_valid <= acc;
            if (acc) begin
                even <= ~n[0];
                odd  <= n[0];
`ifdef EVEN_ODD_PARITY_EN
                parity <= ^n;
`endif
            end
        end
    end
`ifndef EVEN_ODD_PARITY_EN
    // only the LSB matters without parity
    logic [WIDTH-1:0] unused_n;
    assign unused_n = n;
`endif
    even_odd_win_ctr #(.WINDOW(WINDOW), .CNT_W(CNT_W)) u_ctr (
        .clk         (clk),
        .rst         (rst),
        .acc         (acc),
        .lsb         (n[0]),
        .flush       (flush),
`ifdef EVEN_ODD_PARITY_EN
        .par         (^n),
        .win_par_odd (win_par_odd),
`endif
        .state       (state),
        .win_done    (win_done),
        .win_even    (win_even),
        .win_odd     (win_odd)
    );
endmodule

// File: tb/tb_even_odd_window_checker.sv
// tb_even_odd_window_checker: directed checks for WINDOW=4 (8-bit) and WINDOW=1 (16-bit) instances
module tb_even_odd_window_checker;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int checks = 0;
    int errors = 0;

    logic       a_rst = 1'b1, a_valid = 1'b0, a_flush = 1'b0;
    logic [7:0] a_n = '0;
    logic       a_ready, a_even, a_odd, a_ov, a_done;
    logic [4:0] a_we, a_wo;
`ifdef EVEN_ODD_PARITY_EN
    logic       a_par;
    logic [4:0] a_wp;
`endif
    even_odd_window_checker #(.WIDTH(8), .WINDOW(4), .CNT_W(5)) dut_a (
        .clk(clk), .rst(a_rst), .n(a_n), .in_valid(a_valid), .in_ready(a_ready),
        .flush(a_flush), .even(a_even), .odd(a_odd), .out_valid(a_ov),
`ifdef EVEN_ODD_PARITY_EN
        .parity(a_par), .win_par_odd(a_wp),
`endif
        .win_done(a_done), .win_even(a_we), .win_odd(a_wo)
    );

    logic        b_rst = 1'b1, b_valid = 1'b0, b_flush = 1'b0;
    logic [15:0] b_n = '0;
    logic        b_ready, b_even, b_odd, b_ov, b_done;
    logic [4:0]  b_we, b_wo;
`ifdef EVEN_ODD_PARITY_EN
    logic        b_par;
    logic [4:0]  b_wp;
`endif
    even_odd_window_checker #(.WIDTH(16), .WINDOW(1), .CNT_W(5)) dut_b (
        .clk(clk), .rst(b_rst), .n(b_n), .in_valid(b_valid), .in_ready(b_ready),
        .flush(b_flush), .even(b_even), .odd(b_odd), .out_valid(b_ov),
`ifdef EVEN_ODD_PARITY_EN
        .parity(b_par), .win_par_odd(b_wp),
`endif
        .win_done(b_done), .win_even(b_we), .win_odd(b_wo)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] v, input logic e);
        a_n = v;
        a_valid = 1'b1;
        tick();
        check("a_out_valid", a_ov, 1);
        check("a_even", a_even, e);
        check("a_odd", a_odd, !e);
    endtask

    int idx, reports, stalls;
    logic acc;

    initial begin
        a_n = 8'd3;
        a_valid = 1'b1;
        b_valid = 1'b1;
        tick();
        check("rst_ready", a_ready, 0);
        check("rst_flags", {a_even, a_odd, a_ov, a_done}, 0);
        check("rst_counts", {a_we, a_wo}, 0);
        tick();
        check("rst_ready2", a_ready, 0);
        check("rst_ov2", a_ov, 0);
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_rst = 1'b0;
        b_rst = 1'b0;
        #1;
        check("rel_ready", a_ready, 1);
        check("rel_ready_b", b_ready, 1);

        // classification and first window
        send_a(8'd2, 1);
        send_a(8'd3, 0);
        send_a(8'd8, 1);
        check("cls_no_done", a_done, 0);
        send_a(8'd15, 0);
        check("cls_done", a_done, 1);
        check("cls_we", a_we, 2);
        check("cls_wo", a_wo, 2);
        check("cls_ready", a_ready, 0);
        a_valid = 1'b0;
        tick();
        check("cls_done_end", a_done, 0);
        check("cls_ov_end", a_ov, 0);
        check("cls_hold_we", a_we, 2);
        check("cls_hold_flag", a_odd, 1);
        check("cls_ready_back", a_ready, 1);

        // rollover with in_valid held high
        idx = 0;
        reports = 0;
        stalls = 0;
        for (int c = 0; c < 20 && idx < 8; c++) begin
            a_n = 8'(2 * idx + 1);
            a_valid = 1'b1;
            acc = a_ready;
            if (!acc) stalls++;
            tick();
            if (acc) idx++;
            if (a_done) begin
                reports++;
                check("roll_wo", a_wo, 4);
                check("roll_we", a_we, 0);
            end
        end
        a_valid = 1'b0;
        check("roll_accepts", idx, 8);
        check("roll_reports", reports, 2);
        check("roll_stalls", stalls, 1);
        tick();

        // flush with a same-cycle accept
        send_a(8'd4, 1);
        send_a(8'd6, 1);
        a_flush = 1'b1;
        send_a(8'd7, 0);
        a_flush = 1'b0;
        check("fl_no_done0", a_done, 0);
        send_a(8'd9, 0);
        check("fl_no_done1", a_done, 0);
        send_a(8'd11, 0);
        check("fl_no_done2", a_done, 0);
        send_a(8'd13, 0);
        check("fl_done", a_done, 1);
        check("fl_we", a_we, 0);
        check("fl_wo", a_wo, 4);
        a_valid = 1'b0;
        tick();

        // reset mid-window discards counts
        send_a(8'd1, 0);
        send_a(8'd2, 1);
        send_a(8'd3, 0);
        a_valid = 1'b0;
        a_rst = 1'b1;
        tick();
        check("mid_rst_done", a_done, 0);
        check("mid_rst_wo", a_wo, 0);
        a_rst = 1'b0;
        send_a(8'd5, 0);
        send_a(8'd7, 0);
        send_a(8'd9, 0);
        check("mid_no_done", a_done, 0);
        send_a(8'd10, 1);
        check("mid_done", a_done, 1);
        check("mid_we", a_we, 1);
        check("mid_wo", a_wo, 3);
        a_valid = 1'b0;
        tick();

        // WINDOW = 1 boundary
        b_n = 16'hFFFE;
        b_valid = 1'b1;
        tick();
        check("b_even", b_even, 1);
        check("b_ov", b_ov, 1);
        check("b_done", b_done, 1);
        check("b_we", b_we, 1);
        check("b_wo", b_wo, 0);
        check("b_ready", b_ready, 0);
        b_n = 16'h8001;
        tick();
        check("b_stall_done", b_done, 0);
        check("b_stall_ov", b_ov, 0);
        tick();
        check("b_done2", b_done, 1);
        check("b_wo2", b_wo, 1);
        check("b_we2", b_we, 0);
        check("b_odd2", b_odd, 1);
        b_valid = 1'b0;
        tick();

`ifdef EVEN_ODD_PARITY_EN
        send_a(8'h07, 0);
        check("par_07", a_par, 1);
        send_a(8'h03, 0);
        check("par_03", a_par, 0);
        send_a(8'h01, 0);
        send_a(8'h02, 1);
        check("par_win", a_wp, 3);
        a_valid = 1'b0;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
